my_ram: RTL and testbench
=========================

Name: my_ram

Overview:
- Small synchronous single-port-write, dual-read-path RAM: 16 words x 4 bits, clocked by the board 50 MHz clock.
- `sw` selects the mode:
  - sw=0 is load mode: writes are enabled, and the output scans memory at the address on the 4-bit `clk` bus.
  - sw=1 is read mode: writes are blocked, and the output shows the word at `raddr`.
- Sits between the board switches/keys and the 7-seg/LED display logic.

Parameters:
- DATA_W, 4, word width in bits.
- ADDR_W, 4, address width in bits.
- DEPTH, 16, number of words; must equal 2**ADDR_W.

Ports:
- CLOCK_50  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset (asserted when 0).
- clk  input  ADDR_W  scan address from the top-level free-running counter. This is a data input, not a clock; it is sampled on CLOCK_50.
- sw  input  1  mode select: 0 = load/scan, 1 = read.
- we  input  1  write enable, honoured only when sw=0.
- waddr  input  ADDR_W  write address.
- din  input  DATA_W  write data.
- raddr  input  ADDR_W  read address used when sw=1.
- dout  output  DATA_W  registered read data.

Behaviour:
- Storage: DEPTH x DATA_W register array mem[0..DEPTH-1].
- Reset (rst=0, asynchronous):
  - all mem words are cleared to 0 and dout is cleared to 0, immediately and independent of CLOCK_50;
  - mem and dout hold at 0 while rst=0;
  - writes and reads are suppressed during reset.
  - Implement mem as flops, not inferred block RAM, so the clear is possible.
- Reset release: synchronous usage resumes at the first CLOCK_50 rising edge with rst=1.
- Write, at posedge CLOCK_50 with rst=1, sw=0, we=1: mem[waddr] <= din.
- Write blocking: with sw=1, we is ignored and the memory is never modified.
- Read, at each posedge CLOCK_50 with rst=1:
  - sw=0: dout <= mem[clk];
  - sw=1: dout <= mem[raddr].
- Read latency: 1 cycle. dout reflects the address and mode sampled at the previous edge; it holds between edges.
- Read-during-write to the same address in the same cycle: read-before-write. dout gets the old word; the new word is visible from the next edge.
- Mode switch: takes effect on the first edge after sw changes; no extra latency and no glitch cycle beyond that one-edge registration.
- Addresses: full range 0..15, with no out-of-range condition. The unused upper bits of addresses wider than ADDR_W are not applicable because the ports are exactly ADDR_W wide.
- No X propagation: all state has defined reset values.

Test Plan:
- Load: rst=1, sw=0, we=1. Write din=15@waddr0, din=3@waddr1, din=7@waddr2, each held 2 cycles -> after the load, mem[0]=15, mem[1]=3, mem[2]=7, mem[3..15]=0.
- Read: sw=1, we=0; raddr=0, then 1, then 2, each held >=2 cycles -> dout=15, 3, 7 respectively, each valid 1 cycle after the raddr change.
- Scan: sw=0, we=0, clk bus cycling 0..15 -> dout follows mem[clk] one cycle late: 15, 3, 7, then 0 for addresses 3..15.
- Write blocked: sw=1, we=1, waddr=0, din=5, then read raddr=0 -> dout=15 (unchanged).
- Read-during-write: sw=0, we=1, waddr=clk=1, din=9 -> dout=3 on that edge and 9 on the following edge.
- Async reset: drive rst=0 mid-operation between clock edges -> dout=0 immediately. After release, sw=1 and raddr=0, 1, 2 -> dout=0 for all addresses.

Source files
------------

// File: rtl/my_ram.sv
// 16 x 4 flop-based RAM with one write port and a registered read path that
// either scans memory from an external address counter (load mode) or follows raddr (read mode).
module my_ram #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4,
  parameter int DEPTH  = 16
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic [ADDR_W-1:0] clk,
  input  logic              sw,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] din,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] dout
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] dout_q;
  logic [DATA_W-1:0] dout_d;
  logic [DEPTH-1:0]  wsel;
  logic [ADDR_W-1:0] rd_addr;
  logic              wr_en;

  // Writes are only honoured in load mode.
  assign wr_en = we & ~sw;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wdec
      assign wsel[gi] = wr_en && (waddr == ADDR_W'(gi));
    end
  endgenerate

  // Flops rather than block RAM so the whole array can be cleared by reset.
  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (wsel[i]) begin
          mem_q[i] <= din;
        end
      end
    end
  end

  // Reads see the pre-write contents, giving read-before-write on a collision.
  always_comb begin
    rd_addr = sw ? raddr : clk;
    dout_d  = mem_q[rd_addr];
  end

  always_ff @(posedge CLOCK_50 or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_my_ram.sv
// Scoreboard bench for my_ram: stimulus pushes the expected read word, a monitor
// pops one entry after each rising edge and compares it against dout.
module tb_my_ram;

  logic       CLOCK_50 = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] clk = '0;
  logic       sw = 1'b0;
  logic       we = 1'b0;
  logic [3:0] waddr = '0;
  logic [3:0] din = '0;
  logic [3:0] raddr = '0;
  logic [3:0] dout;

  typedef struct {
    logic [3:0] val;
    logic [3:0] addr;
    logic       mode;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] mdl[16];
  int         total = 0;
  int         bad = 0;

  my_ram #(.DATA_W(4), .ADDR_W(4), .DEPTH(16)) dut (
    .CLOCK_50(CLOCK_50),
    .rst(rst),
    .clk(clk),
    .sw(sw),
    .we(we),
    .waddr(waddr),
    .din(din),
    .raddr(raddr),
    .dout(dout)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: dout=%h", name, act);
    end
  endtask

  // One transaction per clock: inputs set on the falling edge, sampled on the next rising edge.
  task automatic cycle(input logic s, input logic w, input logic [3:0] wa,
                       input logic [3:0] d, input logic [3:0] ra, input logic [3:0] ca);
    exp_t e;
    @(negedge CLOCK_50);
    sw = s; we = w; waddr = wa; din = d; raddr = ra; clk = ca;
    e.mode = s;
    e.addr = s ? ra : ca;
    e.val  = mdl[e.addr];
    exp_q.push_back(e);
    if (!s && w) mdl[wa] = d;
  endtask

  // Assert reset between edges, hold it across edges with writes requested, release on a falling edge.
  task automatic async_reset();
    @(posedge CLOCK_50);
    #3 rst = 1'b0;
    #1 chk("reset_immediate", dout, 4'h0);
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge CLOCK_50);
      sw = 1'b0; we = 1'b1; waddr = 4'(k); din = 4'hA; clk = 4'(k);
      chk("reset_hold", dout, 4'h0);
    end
    @(negedge CLOCK_50);
    we = 1'b0;
    rst = 1'b1;
  endtask

  // Monitor: after each rising edge, compare dout against the oldest pending expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge CLOCK_50);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk($sformatf("%s@%0d", e.mode ? "read" : "scan", e.addr), dout, e.val);
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) mdl[i] = '0;
    #2 rst = 1'b0;
    #3 chk("reset_state", dout, 4'h0);
    repeat (2) @(negedge CLOCK_50);
    rst = 1'b1;

    // Load 15, 3, 7 at addresses 0..2, each held two cycles.
    for (int k = 0; k < 2; k++) cycle(0, 1, 4'd0, 4'd15, 4'd0, 4'd0);
    for (int k = 0; k < 2; k++) cycle(0, 1, 4'd1, 4'd3,  4'd0, 4'd0);
    for (int k = 0; k < 2; k++) cycle(0, 1, 4'd2, 4'd7,  4'd0, 4'd0);
    // Read mode.
    for (int a = 0; a < 3; a++)
      for (int k = 0; k < 2; k++) cycle(1, 0, 4'd0, 4'd0, 4'(a), 4'd0);
    // Scan the whole address space.
    for (int a = 0; a < 16; a++) cycle(0, 0, 4'd0, 4'd0, 4'd0, 4'(a));
    // Write attempt in read mode must be ignored.
    cycle(1, 1, 4'd0, 4'd5, 4'd0, 4'd0);
    cycle(1, 0, 4'd0, 4'd0, 4'd0, 4'd0);
    // Read-during-write collision: old word first, new word next edge.
    cycle(0, 1, 4'd1, 4'd9, 4'd0, 4'd1);
    cycle(0, 0, 4'd0, 4'd0, 4'd0, 4'd1);
    // Async reset, then confirm memory cleared.
    async_reset();
    for (int a = 0; a < 3; a++) cycle(1, 0, 4'd0, 4'd0, 4'(a), 4'd0);

    // Randomised traffic with a mid-run reset.
    for (int n = 0; n < 300; n++) begin
      if (n == 150) async_reset();
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom),
            4'($urandom), 4'($urandom), 4'($urandom));
    end

    repeat (3) @(negedge CLOCK_50);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: pending=%0d expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
